puzzle8_top: RTL and testbench
==============================

# puzzle8_top

Top level of an 8-puzzle game on a 3x3 board (tiles 1–8 plus one blank), played with five push-buttons. Four seven-segment digits show one board row at a time together with the row number, or a "done" mark once the puzzle is solved. The block is the complete design: input synchronising, optional debouncing, board state, move logic and display encoding.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable samples a button needs before it is accepted. Used only when `PUZZLE8_DEBOUNCE_EN` is defined.
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is `clk` and the reset port is `rst_n`.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `btn` input, 5 bits, asynchronous buttons, active high:
  - `[0]` up, `[1]` down, `[2]` left, `[3]` right: each moves the blank one cell in that direction.
  - `[4]` select: cycles the displayed row.
- `seg0` output, 7 bits: column 2 (rightmost) tile of the displayed row.
- `seg1` output, 7 bits: column 1 tile.
- `seg2` output, 7 bits: column 0 (leftmost) tile.
- `seg3` output, 7 bits: row number (1–3), or "d" when solved.
- Segment encoding for all `seg*` outputs: active high; bit 0 = segment a … bit 6 = segment g.

## Operation
- Board storage: nine 4-bit cells in row-major order; value 0 is the blank. The blank's position is also tracked as row/column, each 0–2.
- Initial board after reset:
  - Row 0: 1 2 3
  - Row 1: 4 0 6
  - Row 2: 7 5 8
- Goal board: 1 2 3 / 4 5 6 / 7 8 0.
- Move rule: the blank swaps with the neighbouring cell in the chosen direction.
  - Up: row−1. Down: row+1. Left: col−1. Right: col+1.
  - A move that would leave the board (row or col outside 0..2) is ignored; the board is unchanged.
- Solved flag: combinational comparison of the board against the goal.
  - While solved, all direction presses are ignored.
  - Select still works while solved.
  - Only reset leaves the solved state.
- Row select: a 2-bit counter stepping 0→1→2→0, advanced by select.
- Button processing:
  - Each button passes through a 2-flop synchroniser, then rising-edge detection. One press produces exactly one action.
  - If several edges occur in the same cycle, only the highest-priority one acts: up > down > left > right > select. The others are discarded.
- Display codes:
  - 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111
  - Blank tile shows "-" = 1000000.
  - "d" = 1011110.
- `seg3` shows the digit for row select + 1, or "d" when solved.
- Cell values 9–15 cannot occur. If decoded, they show all segments off.

## Timing
- Reset values (applied asynchronously):
  - Board = initial board; row select = 0.
  - `seg3` = 0000110 ("1"); `seg2`/`seg1`/`seg0` = 0000110 / 1011011 / 1001111 ("1 2 3").
- Without debounce, `btn` high sampled at edge k:
  - Synchroniser at edges k and k+1.
  - Edge pulse valid after edge k+1; board/select update at edge k+2.
  - Registered `seg*` update at edge k+3.
- With debounce: an additional `DEBOUNCE_CYCLES` edges of latency. A press shorter than that is ignored.
- A held button produces one action only; the next action needs release and a new press.
- Reset asserted mid-operation immediately restores all reset values, including synchroniser and debounce state.

## Configuration
- `PUZZLE8_DEBOUNCE_EN` defined:
  - Each synchronised button feeds a saturating counter.
  - The accepted level changes only after `DEBOUNCE_CYCLES` consecutive samples that differ from the current accepted level.
  - Edge detection runs on the accepted level.
- Undefined: edge detection runs directly on the synchroniser output.

## Structure
- Package `puzzle8_pkg` holds:
  - Tile type (4-bit).
  - Initial and goal board constants.
  - Seven-segment code constants (1–8, "-", "d", off).
  - Button index constants.
- Sub-module `puzzle8_seg7_decode`: maps a 4-bit tile value or character to the 7-bit segment code. Instantiated four times.
- Everything else stays in `puzzle8_top`.

## Test plan
- Reset released, no presses → `seg3..seg0` = "1","1","2","3"; after one select press → "2","4","-","6".
- Press down, then right, with row 2 selected → `seg3` = "d", `seg2..seg0` = "7","8","-"; further direction presses leave it unchanged.
- From the initial board, press up twice → the first moves the blank to (0,1), showing row 0 as "1","-","3"; the second is ignored.
- Press left and right in the same cycle → only the left move applies; the blank ends at (1,0).
- Hold up for 50 cycles → exactly one move.
- Assert `rst_n` mid-game → outputs return to reset values immediately. With `PUZZLE8_DEBOUNCE_EN`: a 5-cycle pulse is ignored; a (`DEBOUNCE_CYCLES`+2)-cycle press moves the blank.

Source files
------------

// File: rtl/puzzle8_pkg.sv
// Shared types and constants for the 8-puzzle game: tiles, boards, segment codes,
// button indices and the decoded action of a cycle.
package puzzle8_pkg;

   typedef logic [3:0] tile_t;
   typedef logic [8:0][3:0] board_t;   // cell 0 = row 0 col 0, row-major

   typedef enum logic [2:0] {
      ACT_NONE  = 3'd0,
      ACT_UP    = 3'd1,
      ACT_DOWN  = 3'd2,
      ACT_LEFT  = 3'd3,
      ACT_RIGHT = 3'd4,
      ACT_SEL   = 3'd5
   } action_e;

   localparam tile_t TILE_BLANK = 4'd0;

   localparam board_t INIT_BOARD = {4'd8, 4'd5, 4'd7,
                                    4'd6, 4'd0, 4'd4,
                                    4'd3, 4'd2, 4'd1};
   localparam board_t GOAL_BOARD = {4'd0, 4'd8, 4'd7,
                                    4'd6, 4'd5, 4'd4,
                                    4'd3, 4'd2, 4'd1};

   localparam logic [1:0] INIT_BLANK_ROW = 2'd1;
   localparam logic [1:0] INIT_BLANK_COL = 2'd1;

   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_D    = 7'b1011110;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   localparam int unsigned BTN_UP    = 32'd0;
   localparam int unsigned BTN_DOWN  = 32'd1;
   localparam int unsigned BTN_LEFT  = 32'd2;
   localparam int unsigned BTN_RIGHT = 32'd3;
   localparam int unsigned BTN_SEL   = 32'd4;

   function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
      return ({2'b00, row} * 4'd3) + {2'b00, col};
   endfunction

endpackage

// File: rtl/puzzle8_seg7_decode.sv
// Seven-segment encoder: tile value 1-8, blank as "-", or the "d" solved mark.
module puzzle8_seg7_decode
   import puzzle8_pkg::*;
(
   input  logic [3:0] tile_i,
   input  logic       done_i,
   output logic [6:0] seg_o
);

   // Character lookup; the solved mark overrides the tile value.
   always_comb begin
      seg_o = SEG_OFF;
      if (done_i) begin
         seg_o = SEG_D;
      end else begin
         case (tile_i)
            4'd0:    seg_o = SEG_DASH;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            default: seg_o = SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/puzzle8_top.sv
// 8-puzzle game top: button synchronising, edge detection, board moves and display.
// Optional button debouncing is enabled by defining PUZZLE8_DEBOUNCE_EN.
module puzzle8_top
   import puzzle8_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn,
   output logic [6:0] seg0,
   output logic [6:0] seg1,
   output logic [6:0] seg2,
   output logic [6:0] seg3
);

   logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [4:0] acc_s, edge_s;
   action_e    act_s;
   board_t     board_q, board_d;
   logic [1:0] blank_row_q, blank_row_d, blank_col_q, blank_col_d;
   logic [1:0] row_sel_q, row_sel_d, row_eff_s;
   logic [1:0] tgt_row_s, tgt_col_s;
   logic       move_ok_s, solved_s;
   logic [3:0] blank_idx_s, tgt_idx_s;
   logic [6:0] seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d;

   // Two-flop synchroniser and edge-detect history.
   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      prev_d  = acc_s;
   end

`ifdef PUZZLE8_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [4:0]         level_q, level_d;
   logic [4:0][CW-1:0] cnt_q, cnt_d;

   // Accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 5; i++) begin
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync2_q[i];
               cnt_d[i]   = {CW{1'b0}};
            end else begin
               cnt_d[i]   = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            cnt_d[i] = {CW{1'b0}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 5'b00000;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign acc_s = level_q;
`else
   assign acc_s = sync2_q;
`endif

   assign edge_s = acc_s & ~prev_q;

   // Only the highest-priority edge of a cycle acts; the rest are dropped.
   always_comb begin
      act_s = ACT_NONE;
      if (edge_s[BTN_UP]) begin
         act_s = ACT_UP;
      end else if (edge_s[BTN_DOWN]) begin
         act_s = ACT_DOWN;
      end else if (edge_s[BTN_LEFT]) begin
         act_s = ACT_LEFT;
      end else if (edge_s[BTN_RIGHT]) begin
         act_s = ACT_RIGHT;
      end else if (edge_s[BTN_SEL]) begin
         act_s = ACT_SEL;
      end else begin
         act_s = ACT_NONE;
      end
   end

   assign solved_s = (board_q == GOAL_BOARD);

   // Target cell of the blank; off-board moves and moves while solved are rejected.
   always_comb begin
      tgt_row_s = blank_row_q;
      tgt_col_s = blank_col_q;
      move_ok_s = 1'b0;
      case (act_s)
         ACT_UP: begin
            if (blank_row_q != 2'd0) begin
               tgt_row_s = blank_row_q - 2'd1;
               move_ok_s = 1'b1;
            end else begin
               move_ok_s = 1'b0;
            end
         end
         ACT_DOWN: begin
            if (blank_row_q < 2'd2) begin
               tgt_row_s = blank_row_q + 2'd1;
               move_ok_s = 1'b1;
            end else begin
               move_ok_s = 1'b0;
            end
         end
         ACT_LEFT: begin
            if (blank_col_q != 2'd0) begin
               tgt_col_s = blank_col_q - 2'd1;
               move_ok_s = 1'b1;
            end else begin
               move_ok_s = 1'b0;
            end
         end
         ACT_RIGHT: begin
            if (blank_col_q < 2'd2) begin
               tgt_col_s = blank_col_q + 2'd1;
               move_ok_s = 1'b1;
            end else begin
               move_ok_s = 1'b0;
            end
         end
         default: move_ok_s = 1'b0;
      endcase
      if (solved_s) begin
         move_ok_s = 1'b0;
      end else begin
         move_ok_s = move_ok_s;
      end
   end

   assign blank_idx_s = cell_idx(blank_row_q, blank_col_q);
   assign tgt_idx_s   = cell_idx(tgt_row_s, tgt_col_s);

   // Board swap and row-select stepping.
   always_comb begin
      board_d     = board_q;
      blank_row_d = blank_row_q;
      blank_col_d = blank_col_q;
      row_sel_d   = row_sel_q;
      if (move_ok_s) begin
         board_d[blank_idx_s] = board_q[tgt_idx_s];
         board_d[tgt_idx_s]   = TILE_BLANK;
         blank_row_d          = tgt_row_s;
         blank_col_d          = tgt_col_s;
      end else if (act_s == ACT_SEL) begin
         row_sel_d = (row_sel_q >= 2'd2) ? 2'd0 : row_sel_q + 2'd1;
      end else begin
         row_sel_d = row_sel_q;
      end
   end

   assign row_eff_s = (row_sel_q > 2'd2) ? 2'd0 : row_sel_q;

   puzzle8_seg7_decode u_dec0 (
      .tile_i (board_q[cell_idx(row_eff_s, 2'd2)]),
      .done_i (1'b0),
      .seg_o  (seg0_d)
   );
   puzzle8_seg7_decode u_dec1 (
      .tile_i (board_q[cell_idx(row_eff_s, 2'd1)]),
      .done_i (1'b0),
      .seg_o  (seg1_d)
   );
   puzzle8_seg7_decode u_dec2 (
      .tile_i (board_q[cell_idx(row_eff_s, 2'd0)]),
      .done_i (1'b0),
      .seg_o  (seg2_d)
   );
   puzzle8_seg7_decode u_dec3 (
      .tile_i ({2'b00, row_eff_s} + 4'd1),
      .done_i (solved_s),
      .seg_o  (seg3_d)
   );

   // State and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 5'b00000;
         sync2_q     <= 5'b00000;
         prev_q      <= 5'b00000;
         board_q     <= INIT_BOARD;
         blank_row_q <= INIT_BLANK_ROW;
         blank_col_q <= INIT_BLANK_COL;
         row_sel_q   <= 2'd0;
         seg0_q      <= SEG_3;
         seg1_q      <= SEG_2;
         seg2_q      <= SEG_1;
         seg3_q      <= SEG_1;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         board_q     <= board_d;
         blank_row_q <= blank_row_d;
         blank_col_q <= blank_col_d;
         row_sel_q   <= row_sel_d;
         seg0_q      <= seg0_d;
         seg1_q      <= seg1_d;
         seg2_q      <= seg2_d;
         seg3_q      <= seg3_d;
      end
   end

   assign seg0 = seg0_q;
   assign seg1 = seg1_q;
   assign seg2 = seg2_q;
   assign seg3 = seg3_q;

endmodule

// File: tb/tb_puzzle8_top.sv
// Scoreboard bench for puzzle8_top: directed button sequences push expected
// displays into a queue; a monitor on the falling edge pops and compares.
module tb_puzzle8_top;

   localparam int DB = 16;
`ifdef PUZZLE8_DEBOUNCE_EN
   localparam int LAT = DB;
   localparam int HOLD = DB + 2;
`else
   localparam int LAT = 0;
   localparam int HOLD = 2;
`endif
   localparam int SETTLE = LAT + 6;
   localparam int D_CHAR = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn = 5'b00000;
   logic [6:0] seg0, seg1, seg2, seg3;

   typedef struct {
      string       name;
      logic [27:0] exp;
   } chk_t;

   chk_t exp_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   puzzle8_top #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .seg0  (seg0),
      .seg1  (seg1),
      .seg2  (seg2),
      .seg3  (seg3)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] tseg(input int t);
      case (t)
         0:       return 7'b1000000;
         1:       return 7'b0000110;
         2:       return 7'b1011011;
         3:       return 7'b1001111;
         4:       return 7'b1100110;
         5:       return 7'b1101101;
         6:       return 7'b1111101;
         7:       return 7'b0000111;
         8:       return 7'b1111111;
         D_CHAR:  return 7'b1011110;
         default: return 7'b0000000;
      endcase
   endfunction

   // Monitor: compare the display against each queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         chk_t e;
         logic [27:0] act;
         e = exp_q.pop_front();
         act = {seg3, seg2, seg1, seg0};
         n_cmp++;
         if (act !== e.exp) begin
            n_mis++;
            $display("FAIL %s: got seg3..0=%b_%b_%b_%b expected %b_%b_%b_%b", e.name,
                     act[27:21], act[20:14], act[13:7], act[6:0],
                     e.exp[27:21], e.exp[20:14], e.exp[13:7], e.exp[6:0]);
         end
      end
   end

   task automatic chk(input string name, input int s3, input int a, input int b, input int c);
      chk_t e;
      e.name = name;
      e.exp  = {tseg(s3), tseg(a), tseg(b), tseg(c)};
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] mask, input int hold);
      btn = mask;
      repeat (hold) @(posedge clk);
      #1;
      btn = 5'b00000;
      repeat (SETTLE) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold", 1, 1, 2, 3);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle", 1, 1, 2, 3);

      // exact latency of one select press
      @(posedge clk);
      #1;
      btn = 5'b10000;
      repeat (3 + LAT) @(posedge clk);
      #1;
      chk("lat_before", 1, 1, 2, 3);
      @(posedge clk);
      #1;
      chk("lat_after", 2, 4, 0, 6);
      btn = 5'b00000;
      repeat (SETTLE) @(posedge clk);
      #1;

      // up twice: second move leaves the board
      press(5'b00001, HOLD);
      chk("up_row1", 2, 4, 2, 6);
      press(5'b10000, HOLD);
      press(5'b10000, HOLD);
      chk("up1", 1, 1, 0, 3);
      press(5'b00001, HOLD);
      chk("up2_ignored", 1, 1, 0, 3);

      // held button acts once
      press(5'b10000, HOLD);
      chk("sel_row1", 2, 4, 2, 6);
      press(5'b00010, 50);
      chk("hold_down", 2, 4, 0, 6);

      // left and right together: left wins
      press(5'b01100, HOLD);
      chk("left_right", 2, 0, 4, 6);

      // asynchronous reset mid-game
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      chk("rst_mid", 1, 1, 2, 3);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // solve: down then right with row 2 selected
      press(5'b10000, HOLD);
      press(5'b10000, HOLD);
      chk("row2", 3, 7, 5, 8);
      press(5'b00010, HOLD);
      chk("down", 3, 7, 0, 8);
      press(5'b01000, HOLD);
      chk("solved", D_CHAR, 7, 8, 0);
      press(5'b00001, HOLD);
      chk("solved_up", D_CHAR, 7, 8, 0);
      press(5'b00100, HOLD);
      chk("solved_left", D_CHAR, 7, 8, 0);
      press(5'b10000, HOLD);
      chk("solved_sel", D_CHAR, 1, 2, 3);

`ifdef PUZZLE8_DEBOUNCE_EN
      do_reset();
      press(5'b00001, 5);
      chk("short_pulse", 1, 1, 2, 3);
      press(5'b00001, DB + 2);
      chk("long_press", 1, 1, 0, 3);
`endif

      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
      end
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required end of run");
      $fatal(1, "watchdog");
   end

endmodule
